updown_mod_counter: RTL and testbench

//   Parametrised up/down modulo counter; successor to the fixed 10-bit LEDR counter.

---
 rtl/updown_mod_counter.sv | 103 ++++++++++
 tb/tb_updown_mod_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate, clamped parallel load and step/terminal-count strobes.
// Optional clock-enable prescaler is built only when CNT_PRESCALE_EN is defined.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned MODULO   = 1000,
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_sat,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_dat,
  output logic [WIDTH-1:0] o_cnt_dat,
  output logic             o_tc,
  output logic             o_tick
);

  // Largest legal count; MODULO itself may be 2**WIDTH, so only MODULO-1 is held in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic             pre_tick;
  logic             step;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_cnt;
  logic             step_tc;

`ifdef CNT_PRESCALE_EN
  localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;

  assign pre_tick = (pre_cnt == PRE_LAST);

  // Prescaler only advances on enabled cycles; a load restarts the phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_cnt <= '0;
    end else if (i_load) begin
      pre_cnt <= '0;
    end else if (i_en) begin
      pre_cnt <= pre_tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end
`else
  // No prescaler: every enabled cycle is a step (PRESCALE of zero is not a legal setting).
  assign pre_tick = (PRESCALE != 0);
`endif

  assign step = i_en & pre_tick;

  // Load value clamped into the count range.
  always_comb begin
    load_val = i_load_dat;
    if (i_load_dat > MAX_VAL) begin
      load_val = MAX_VAL;
    end
  end

  // Next count and terminal-count flag for a step in the sampled direction/mode.
  always_comb begin
    step_cnt = o_cnt_dat;
    step_tc  = 1'b0;
    if (i_dir) begin
      if (o_cnt_dat < MAX_VAL) begin
        step_cnt = o_cnt_dat + WIDTH'(1);
      end else begin
        step_cnt = i_sat ? MAX_VAL : '0;
        step_tc  = 1'b1;
      end
    end else begin
      if (o_cnt_dat > '0) begin
        step_cnt = o_cnt_dat - WIDTH'(1);
      end else begin
        step_cnt = i_sat ? '0 : MAX_VAL;
        step_tc  = 1'b1;
      end
    end
  end

  // Count and strobes share one register stage so they always line up.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_dat <= '0;
      o_tc      <= 1'b0;
      o_tick    <= 1'b0;
    end else if (i_load) begin
      o_cnt_dat <= load_val;
      o_tc      <= 1'b0;
      o_tick    <= 1'b0;
    end else if (step) begin
      o_cnt_dat <= step_cnt;
      o_tc      <= step_tc;
      o_tick    <= 1'b1;
    end else begin
      o_tc      <= 1'b0;
      o_tick    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MODULO=10, PRESCALE=4).
// Default build runs the vector table; with CNT_PRESCALE_EN defined it runs the prescaler sequences.
module tb_updown_mod_counter;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned MODULO   = 10;
  localparam int unsigned PRESCALE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             dir;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_dat;
  logic [WIDTH-1:0] cnt_dat;
  logic             tc;
  logic             tick;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             rst;
    logic             en;
    logic             dir;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] ld;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             tick;
  } vec_t;

  vec_t vecs[$];

  updown_mod_counter #(
    .WIDTH   (WIDTH),
    .MODULO  (MODULO),
    .PRESCALE(PRESCALE)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_dir     (dir),
    .i_sat     (sat),
    .i_load    (load),
    .i_load_dat(load_dat),
    .o_cnt_dat (cnt_dat),
    .o_tc      (tc),
    .o_tick    (tick)
  );

  always #10 clk = ~clk;

  function automatic void add(input logic r, input logic e, input logic d, input logic s,
                              input logic l, input int ld, input int c, input logic t,
                              input logic k);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.sat = s; v.load = l;
    v.ld = WIDTH'(ld); v.cnt = WIDTH'(c); v.tc = t; v.tick = k;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input int act_cnt, input int exp_cnt,
                       input logic act_tc, input logic exp_tc, input logic act_tick,
                       input logic exp_tick);
    checks++;
    if (act_cnt != exp_cnt || act_tc !== exp_tc || act_tick !== exp_tick) begin
      errors++;
      $display("FAIL %s[%0d]: got cnt=%0d tc=%b tick=%b, expected cnt=%0d tc=%b tick=%b",
               name, idx, act_cnt, act_tc, act_tick, exp_cnt, exp_tc, exp_tick);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic s,
                       input logic l, input int ld);
    rst = r; en = e; dir = d; sat = s; load = l; load_dat = WIDTH'(ld);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tick_cnt;
    rst = 1'b1; en = 1'b0; dir = 1'b1; sat = 1'b0; load = 1'b0; load_dat = '0;
    #1;

`ifndef CNT_PRESCALE_EN
    // r  en dir sat ld dat   cnt tc tick
    add(1, 0, 1, 0, 0, 0,    0, 0, 0);
    // up, wrap: 1..9, 0 (tc), 1
    for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, 0, 0, i, 0, 1);
    add(0, 1, 1, 0, 0, 0,    0, 1, 1);
    add(0, 1, 1, 0, 0, 0,    1, 0, 1);
    // load 3, down wrap
    add(0, 1, 0, 0, 1, 3,    3, 0, 0);
    add(0, 1, 0, 0, 0, 0,    2, 0, 1);
    add(0, 1, 0, 0, 0, 0,    1, 0, 1);
    add(0, 1, 0, 0, 0, 0,    0, 0, 1);
    add(0, 1, 0, 0, 0, 0,    9, 1, 1);
    add(0, 1, 0, 0, 0, 0,    8, 0, 1);
    // clamped loads
    add(0, 1, 0, 0, 1, 12,   9, 0, 0);
    add(0, 1, 0, 0, 1, 10,   9, 0, 0);
    add(0, 1, 0, 0, 1, 15,   9, 0, 0);
    add(0, 0, 0, 0, 1, 4,    4, 0, 0);
    // saturate up from 8
    add(0, 1, 1, 1, 1, 8,    8, 0, 0);
    add(0, 1, 1, 1, 0, 0,    9, 0, 1);
    add(0, 1, 1, 1, 0, 0,    9, 1, 1);
    add(0, 1, 1, 1, 0, 0,    9, 1, 1);
    add(0, 1, 1, 1, 0, 0,    9, 1, 1);
    // saturate down from 1
    add(0, 1, 0, 1, 1, 1,    1, 0, 0);
    add(0, 1, 0, 1, 0, 0,    0, 0, 1);
    add(0, 1, 0, 1, 0, 0,    0, 1, 1);
    add(0, 1, 0, 1, 0, 0,    0, 1, 1);
    // enable toggling, up wrap from 5
    add(0, 0, 1, 0, 1, 5,    5, 0, 0);
    add(0, 1, 1, 0, 0, 0,    6, 0, 1);
    add(0, 0, 1, 0, 0, 0,    6, 0, 0);
    add(0, 1, 1, 0, 0, 0,    7, 0, 1);
    add(0, 0, 1, 0, 0, 0,    7, 0, 0);
    add(0, 1, 1, 0, 0, 0,    8, 0, 1);
    add(0, 1, 1, 0, 0, 0,    9, 0, 1);
    add(0, 0, 1, 0, 0, 0,    9, 0, 0);
    add(0, 1, 1, 0, 0, 0,    0, 1, 1);
    add(0, 0, 1, 0, 0, 0,    0, 0, 0);
    // direction change at the limit: wrap down then back up
    add(0, 1, 0, 0, 0, 0,    9, 1, 1);
    add(0, 1, 1, 0, 0, 0,    0, 1, 1);
    add(0, 1, 1, 0, 0, 0,    1, 0, 1);
    // reset with load while counting at 6
    add(0, 1, 1, 0, 1, 5,    5, 0, 0);
    add(0, 1, 1, 0, 0, 0,    6, 0, 1);
    add(1, 1, 1, 0, 1, 3,    0, 0, 0);
    add(0, 1, 1, 0, 0, 0,    1, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].sat, vecs[i].load, int'(vecs[i].ld));
      check("vec", i, int'(cnt_dat), int'(vecs[i].cnt), tc, vecs[i].tc, tick, vecs[i].tick);
    end

    // 40 enabled cycles from reset: a step every cycle
    drive(1, 0, 1, 0, 0, 0);
    check("rst40", 0, int'(cnt_dat), 0, tc, 1'b0, tick, 1'b0);
    tick_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      drive(0, 1, 1, 0, 0, 0);
      if (tick) tick_cnt++;
    end
    check("steps40", 0, tick_cnt, 40, tc, 1'b1, 1'b0, 1'b0);
    check("cnt40", 0, int'(cnt_dat), 0, 1'b0, 1'b0, tick, 1'b1);
`else
    // 40 enabled cycles from reset: a step every 4th cycle
    drive(1, 0, 1, 0, 0, 0);
    check("rst40", 0, int'(cnt_dat), 0, tc, 1'b0, tick, 1'b0);
    tick_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      drive(0, 1, 1, 0, 0, 0);
      if (tick) tick_cnt++;
      check("pre_tick", c, int'(cnt_dat), c / 4 % 10, 1'b0, 1'b0, tick, (c % 4) == 0);
    end
    check("steps40", 0, tick_cnt, 10, 1'b0, 1'b0, 1'b0, 1'b0);

    // load at prescale phase 2 restarts the phase
    drive(1, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 1, 5);
    check("pre_load", 0, int'(cnt_dat), 5, tc, 1'b0, tick, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      drive(0, 1, 1, 0, 0, 0);
      check("pre_wait", c, int'(cnt_dat), 5, tc, 1'b0, tick, 1'b0);
    end
    // disabled cycles freeze the prescaler
    drive(0, 0, 1, 0, 0, 0);
    check("pre_frz", 0, int'(cnt_dat), 5, tc, 1'b0, tick, 1'b0);
    drive(0, 1, 1, 0, 0, 0);
    check("pre_step", 0, int'(cnt_dat), 6, tc, 1'b0, tick, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
